// File: rtl/wasm_frame_stack.sv
// Operand/frame stack for the WASM CPU datapath. It keeps operands and frame locals in one memory,
// saves frame pointers across calls, zero-fills newly declared locals and latches stack faults.
module wasm_frame_stack #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 256,
    parameter int FRAME_DEPTH = 16,
    localparam int SPW        = $clog2(DEPTH) + 1,
    localparam int FLW        = $clog2(FRAME_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       pop_num,
    input  logic             push_en,
    input  logic [WIDTH-1:0] push_data,
    input  logic             call,
    input  logic             ret,
    input  logic [7:0]       param_num,
    input  logic [7:0]       local_num,
    input  logic [7:0]       local_idx,
    input  logic             local_set,
    input  logic [WIDTH-1:0] local_set_data,
    output logic [WIDTH-1:0] local_get_data,
    output logic [WIDTH-1:0] win_a,
    output logic [WIDTH-1:0] win_b,
    output logic [WIDTH-1:0] win_c,
    output logic [SPW-1:0]   sp,
    output logic [SPW-1:0]   fp,
    output logic [FLW-1:0]   frame_level,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [1:0]       dbg_state
);
    localparam int AW  = $clog2(DEPTH);
    localparam int FAW = $clog2(FRAME_DEPTH);
    localparam int EW  = SPW + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ZERO  = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t state, state_d;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SPW-1:0]   fstack [FRAME_DEPTH];
    logic [SPW-1:0]   zcnt;

    // Handshake: an op is taken on a posedge where op_valid && op_ready; op_ready is high only in IDLE
    // and the requester must hold its op fields stable while op_valid is high and op_ready is low.
    logic accept, op_do, op_fault;
    logic [2:0] fault_code;

    logic [EW-1:0] sp_x, fp_x, pop_x, par_x, loc_x, idx_x;
    logic [EW-1:0] sp1_x, new_fp_x, next_sp_x, local_addr_x;

    logic          set_we, push_we, zero_we;
    logic [AW-1:0] set_addr, push_addr, zero_addr;

    assign sp_x         = EW'(sp);
    assign fp_x         = EW'(fp);
    assign pop_x        = EW'(pop_num);
    assign par_x        = EW'(param_num);
    assign loc_x        = EW'(local_num);
    assign idx_x        = EW'(local_idx);
    assign sp1_x        = sp_x - pop_x;
    assign new_fp_x     = sp1_x - par_x;
    assign local_addr_x = fp_x + idx_x;

    always_comb begin
        next_sp_x = sp1_x + EW'(push_en);
        if (call) begin
            next_sp_x = sp1_x + loc_x;
        end else if (ret) begin
            next_sp_x = fp_x + EW'(push_en);
        end
    end

    // Fault priority: illegal combination, underflow, frame underflow, frame overflow, overflow, local range.
    always_comb begin
        fault_code = 3'd0;
        if (call && (ret || push_en || local_set)) begin
            fault_code = 3'd6;
        end else if ((pop_x > sp_x - fp_x) || (call && (par_x > sp1_x - fp_x))) begin
            fault_code = 3'd1;
        end else if (ret && (frame_level == '0)) begin
            fault_code = 3'd4;
        end else if (call && (frame_level == FLW'(FRAME_DEPTH))) begin
            fault_code = 3'd3;
        end else if (next_sp_x > EW'(DEPTH)) begin
            fault_code = 3'd2;
        end else if (local_set && (local_addr_x >= sp_x)) begin
            fault_code = 3'd5;
        end
    end

    assign accept   = op_valid && op_ready;
    assign op_fault = accept && (fault_code != 3'd0);
    assign op_do    = accept && (fault_code == 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (op_fault) begin
                    state_d = S_ERROR;
                end else if (op_do && call && (local_num != 8'd0)) begin
                    state_d = S_ZERO;
                end
            end
            S_ZERO: begin
                if (zcnt == sp - SPW'(1)) begin
                    state_d = S_IDLE;
                end
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    assign op_ready  = (state == S_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp          <= '0;
            fp          <= '0;
            frame_level <= '0;
            err         <= 1'b0;
            err_code    <= 3'd0;
            zcnt        <= '0;
        end else begin
            if (op_fault) begin
                err      <= 1'b1;
                err_code <= fault_code;
            end
            if (op_do) begin
                sp <= SPW'(next_sp_x);
                if (call) begin
                    fp          <= SPW'(new_fp_x);
                    frame_level <= frame_level + FLW'(1);
                    zcnt        <= SPW'(sp1_x);
                end else if (ret) begin
                    fp          <= fstack[FAW'(frame_level - FLW'(1))];
                    frame_level <= frame_level - FLW'(1);
                end
            end else if (state == S_ZERO) begin
                zcnt <= zcnt + SPW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (op_do && call) begin
            fstack[FAW'(frame_level)] <= fp;
        end
    end

    assign set_we    = op_do && local_set;
    assign set_addr  = AW'(local_addr_x);
    assign push_we   = op_do && push_en;
    assign push_addr = ret ? AW'(fp_x) : AW'(sp1_x);
    assign zero_we   = (state == S_ZERO);
    assign zero_addr = AW'(zcnt);

    // The push write comes last so it overrides a local_set aimed at the same word.
    always_ff @(posedge clk) begin
        if (set_we) begin
            mem[set_addr] <= local_set_data;
        end
        if (push_we) begin
            mem[push_addr] <= push_data;
        end
        if (zero_we) begin
            mem[zero_addr] <= '0;
        end
    end

    assign win_a = (sp_x >= EW'(1)) ? mem[AW'(sp_x - EW'(1))] : '0;
    assign win_b = (sp_x >= EW'(2)) ? mem[AW'(sp_x - EW'(2))] : '0;
    assign win_c = (sp_x >= EW'(3)) ? mem[AW'(sp_x - EW'(3))] : '0;

    assign local_get_data = (local_addr_x < sp_x) ? mem[AW'(local_addr_x)] : '0;

endmodule

// File: tb/tb_wasm_frame_stack.sv
// Bench for wasm_frame_stack: directed steps plus random ops, checked against a word-level stack model.
module tb_wasm_frame_stack;
    localparam int WIDTH       = 32;
    localparam int DEPTH       = 256;
    localparam int FRAME_DEPTH = 16;
    localparam int SPW         = 9;
    localparam int FLW         = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [1:0]       pop_num = '0;
    logic             push_en = 1'b0;
    logic [WIDTH-1:0] push_data = '0;
    logic             call = 1'b0;
    logic             ret = 1'b0;
    logic [7:0]       param_num = '0;
    logic [7:0]       local_num = '0;
    logic [7:0]       local_idx = '0;
    logic             local_set = 1'b0;
    logic [WIDTH-1:0] local_set_data = '0;
    logic [WIDTH-1:0] local_get_data, win_a, win_b, win_c;
    logic [SPW-1:0]   sp, fp;
    logic [FLW-1:0]   frame_level;
    logic             err;
    logic [2:0]       err_code;
    logic [1:0]       dbg_state;

    wasm_frame_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAME_DEPTH(FRAME_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .pop_num(pop_num), .push_en(push_en), .push_data(push_data),
        .call(call), .ret(ret), .param_num(param_num), .local_num(local_num),
        .local_idx(local_idx), .local_set(local_set), .local_set_data(local_set_data),
        .local_get_data(local_get_data), .win_a(win_a), .win_b(win_b), .win_c(win_c),
        .sp(sp), .fp(fp), .frame_level(frame_level), .err(err), .err_code(err_code),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: plain integer stack with a queue of saved frame bases.
    logic [WIDTH-1:0] m_mem [DEPTH];
    int m_sp, m_fp, m_err, m_code, cur_idx;
    int m_frames[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_win(input int k);
        return (m_sp >= k) ? m_mem[m_sp - k] : '0;
    endfunction

    function automatic logic [WIDTH-1:0] exp_local(input int idx);
        return (m_fp + idx < m_sp) ? m_mem[m_fp + idx] : '0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ":sp"}, 64'(sp), 64'(m_sp));
        check({tag, ":fp"}, 64'(fp), 64'(m_fp));
        check({tag, ":level"}, 64'(frame_level), 64'(m_frames.size()));
        check({tag, ":err"}, 64'(err), 64'(m_err));
        check({tag, ":err_code"}, 64'(err_code), 64'(m_code));
        check({tag, ":op_ready"}, 64'(op_ready), 64'(m_err == 0));
        check({tag, ":win_a"}, 64'(win_a), 64'(exp_win(1)));
        check({tag, ":win_b"}, 64'(win_b), 64'(exp_win(2)));
        check({tag, ":win_c"}, 64'(win_c), 64'(exp_win(3)));
        check({tag, ":local_get"}, 64'(local_get_data), 64'(exp_local(cur_idx)));
    endtask

    task automatic model_reset();
        m_sp = 0;
        m_fp = 0;
        m_err = 0;
        m_code = 0;
        m_frames.delete();
    endtask

    task automatic model_op(input int pop, input int pe, input logic [WIDTH-1:0] pdata,
                            input int c, input int r, input int par, input int loc,
                            input int idx, input int s, input logic [WIDTH-1:0] sdata,
                            output int busy);
        int sp1, nsp, code;
        busy = 0;
        code = 0;
        sp1 = m_sp - pop;
        nsp = c ? sp1 + loc : (r ? m_fp + pe : sp1 + pe);
        if (c && (r || pe || s)) code = 6;
        else if (pop > m_sp - m_fp || (c && par > sp1 - m_fp)) code = 1;
        else if (r && m_frames.size() == 0) code = 4;
        else if (c && m_frames.size() == FRAME_DEPTH) code = 3;
        else if (nsp > DEPTH) code = 2;
        else if (s && m_fp + idx >= m_sp) code = 5;
        if (code != 0) begin
            m_err = 1;
            m_code = code;
            return;
        end
        if (s) m_mem[m_fp + idx] = sdata;
        if (c) begin
            m_frames.push_back(m_fp);
            m_fp = sp1 - par;
            for (int i = sp1; i < sp1 + loc; i++) m_mem[i] = '0;
            m_sp = sp1 + loc;
            busy = loc;
        end else if (r) begin
            if (pe) m_mem[m_fp] = pdata;
            m_sp = m_fp + pe;
            m_fp = m_frames.pop_back();
        end else begin
            if (pe) m_mem[sp1] = pdata;
            m_sp = sp1 + pe;
        end
    endtask

    task automatic drive_idle();
        op_valid = 1'b0;
        pop_num = '0;
        push_en = 1'b0;
        call = 1'b0;
        ret = 1'b0;
        param_num = '0;
        local_num = '0;
        local_set = 1'b0;
        local_idx = 8'(cur_idx);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_all(tag);
    endtask

    task automatic send_op(input int pop, input int pe, input logic [WIDTH-1:0] pdata,
                           input int c, input int r, input int par, input int loc,
                           input int idx, input int s, input logic [WIDTH-1:0] sdata,
                           input string tag);
        int busy, lows, was_err;
        was_err = m_err;
        busy = 0;
        @(negedge clk);
        pop_num = 2'(pop);
        push_en = (pe != 0);
        push_data = pdata;
        call = (c != 0);
        ret = (r != 0);
        param_num = 8'(par);
        local_num = 8'(loc);
        cur_idx = idx;
        local_idx = 8'(idx);
        local_set = (s != 0);
        local_set_data = sdata;
        op_valid = 1'b1;
        @(posedge clk);
        if (was_err == 0) model_op(pop, pe, pdata, c, r, par, loc, idx, s, sdata, busy);
        @(negedge clk);
        drive_idle();
        if (m_err == 0) begin
            lows = 0;
            while (op_ready !== 1'b1 && lows < 400) begin
                lows++;
                @(negedge clk);
            end
            check({tag, ":busy_cycles"}, 64'(lows), 64'(busy));
        end
        check_all(tag);
    endtask

    task automatic peek_local(input int idx, input logic [WIDTH-1:0] exp, input string tag);
        @(negedge clk);
        cur_idx = idx;
        local_idx = 8'(idx);
        #1;
        check(tag, 64'(local_get_data), 64'(exp));
        check({tag, ":model"}, 64'(local_get_data), 64'(exp_local(idx)));
    endtask

    initial begin
        int pop, pe, c, r, par, loc, idx, s, kind, avail, lim;
        cur_idx = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        model_reset();

        do_reset("reset");

        send_op(0, 1, 10, 0, 0, 0, 0, 0, 0, 0, "push10");
        check("sp1_win_b_zero", 64'(win_b), 64'(0));
        send_op(0, 1, 20, 0, 0, 0, 0, 0, 0, 0, "push20");
        send_op(0, 1, 30, 0, 0, 0, 0, 0, 0, 0, "push30");
        check("push3_win_a", 64'(win_a), 64'(30));
        check("push3_win_b", 64'(win_b), 64'(20));
        check("push3_win_c", 64'(win_c), 64'(10));

        @(negedge clk);
        push_en = 1'b1;
        push_data = 32'hdead;
        op_valid = 1'b0;
        @(negedge clk);
        drive_idle();
        check_all("no_valid");

        send_op(0, 0, 0, 1, 0, 2, 2, 0, 0, 0, "call_p2_l2");
        check("call_fp", 64'(fp), 64'(1));
        check("call_sp", 64'(sp), 64'(5));
        check("call_level", 64'(frame_level), 64'(1));
        peek_local(0, 20, "local0");
        peek_local(1, 30, "local1");
        peek_local(2, 0, "local2");
        peek_local(3, 0, "local3");
        peek_local(4, 0, "local4_out_of_range");

        send_op(0, 0, 0, 0, 0, 0, 0, 3, 1, 7, "local_set3");
        peek_local(3, 7, "local3_after_set");
        send_op(0, 1, 99, 0, 1, 0, 0, 0, 0, 0, "ret_push99");
        check("ret_sp", 64'(sp), 64'(2));
        check("ret_fp", 64'(fp), 64'(0));
        check("ret_win_a", 64'(win_a), 64'(99));
        check("ret_win_b", 64'(win_b), 64'(10));

        send_op(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "pop1");
        send_op(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, "pop2_underflow");
        check("underflow_code", 64'(err_code), 64'(1));
        check("underflow_sp", 64'(sp), 64'(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("error_not_ready", 64'(op_ready), 64'(0));
        end
        send_op(0, 1, 55, 0, 0, 0, 0, 0, 0, 0, "op_in_error");
        do_reset("reset_after_underflow");

        for (int i = 0; i < DEPTH; i++) send_op(0, 1, $urandom, 0, 0, 0, 0, 0, 0, 0, "fill");
        send_op(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "overflow_push");
        check("overflow_code", 64'(err_code), 64'(2));
        do_reset("reset_after_overflow");

        for (int i = 0; i < FRAME_DEPTH; i++) send_op(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "nest_call");
        send_op(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "frame_overflow");
        check("frame_overflow_code", 64'(err_code), 64'(3));
        do_reset("reset_after_frame_overflow");
        send_op(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "frame_underflow");
        check("frame_underflow_code", 64'(err_code), 64'(4));
        do_reset("reset_after_frame_underflow");

        @(negedge clk);
        call = 1'b1;
        local_num = 8'd100;
        op_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        check("fill100_busy", 64'(op_ready), 64'(0));
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("midfill_rst_sp", 64'(sp), 64'(0));
        check("midfill_rst_fp", 64'(fp), 64'(0));
        check("midfill_rst_level", 64'(frame_level), 64'(0));
        check("midfill_rst_err", 64'(err), 64'(0));
        check("midfill_rst_code", 64'(err_code), 64'(0));
        check("midfill_rst_win_a", 64'(win_a), 64'(0));
        check("midfill_rst_ready", 64'(op_ready), 64'(1));
        rst_n = 1'b1;
        model_reset();
        check_all("after_midfill_reset");
        send_op(0, 1, 123, 0, 0, 0, 0, 0, 0, 0, "push_after_midfill");

        for (int ep = 0; ep < 6; ep++) begin
            do_reset("rnd_reset");
            for (int n = 0; n < 80 && m_err == 0; n++) begin
                kind = $urandom_range(0, 99);
                avail = m_sp - m_fp;
                lim = (avail < 3) ? avail : 3;
                pop = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : $urandom_range(0, lim);
                pe = $urandom_range(0, 1);
                c = 0; r = 0; par = 0; loc = 0; s = 0;
                idx = $urandom_range(0, 7);
                if (kind < 15) begin
                    c = 1;
                    pe = 0;
                    lim = avail - pop;
                    if (lim < 0) lim = 0;
                    if (lim > 3) lim = 3;
                    par = $urandom_range(0, lim);
                    loc = $urandom_range(0, 4);
                end else if (kind < 30 && m_frames.size() > 0) begin
                    r = 1;
                end else if (kind < 50) begin
                    s = 1;
                    idx = (avail > 0) ? $urandom_range(0, avail - 1) : 0;
                end
                if ($urandom_range(0, 49) == 0) begin
                    c = $urandom_range(0, 1);
                    r = $urandom_range(0, 1);
                    s = $urandom_range(0, 1);
                end
                send_op(pop, pe, $urandom, c, r, par, loc, idx, s, $urandom, "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
